// File: rtl/mdu_hilo_ctrl.sv
// rtl/mdu_hilo_ctrl.sv - HI/LO owner and fixed-latency multiply/divide sequencer
// Result is computed at issue and held in pending regs until the latency expires.
module mdu_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_uses_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe_s, rt_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        is_arith;

  // Signed product: sign-extend both operands, the low 64 bits of the 64x64 product are exact.
  always_comb begin
    prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // Signed divide on magnitudes; 0x80000000 / -1 falls out naturally as q=0x80000000, r=0.
  always_comb begin
    a_mag    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    b_mag    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    b_safe_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    rt_safe  = (rt_val == 32'd0) ? 32'd1 : rt_val;
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    q_s      = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s      = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    q_u      = rs_val / rt_safe;
    r_u      = rs_val % rt_safe;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: begin
        res_hi = (rt_val == 32'd0) ? rs_val : r_s;
        res_lo = (rt_val == 32'd0) ? 32'hFFFF_FFFF : q_s;
      end
      3'd3: begin
        res_hi = (rt_val == 32'd0) ? rs_val : r_u;
        res_lo = (rt_val == 32'd0) ? 32'hFFFF_FFFF : q_u;
      end
      default: ;
    endcase
  end

  assign is_arith = (md_op <= 3'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          if (is_arith) begin
            phi_d   = res_hi;
            plo_d   = res_lo;
            cnt_d   = md_op[1] ? DIV_LOAD : MULT_LOAD;
            state_d = ST_BUSY;
          end else if (md_op == 3'd4) begin
            hi_d = rs_val;
          end else if (md_op == 3'd5) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == ST_BUSY);
  assign stall = id_uses_md & (busy | (md_start & is_arith & (state_q == ST_IDLE)));

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb/tb_mdu_hilo_ctrl.sv - scoreboard bench for mdu_hilo_ctrl
module tb_mdu_hilo_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        id_uses_md;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_hilo_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .md_start(md_start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .id_uses_md(id_uses_md),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint a, b, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] v;
    v = {m_hi, m_lo};
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      3'd0: v = a * b;
      3'd1: v = ua * ub;
      3'd2: begin
        if (rt == 32'd0) v = {rs, 32'hFFFF_FFFF};
        else begin
          q = a / b;
          r = a % b;
          v = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (rt == 32'd0) v = {rs, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          v = {ur[31:0], uq[31:0]};
        end
      end
      3'd4: v = {rs, m_lo};
      3'd5: v = {m_hi, rs};
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic uses, input string tag);
    int cyc;
    int lim;
    logic [63:0] e;
    @(negedge clk);
    md_start = 1'b1; md_op = op; rs_val = rs; rt_val = rt; id_uses_md = uses;
    exp_q.push_back(model(op, rs, rt));
    #1;
    check_eq({tag, " stall_issue"}, {63'd0, stall}, {63'd0, uses && (op <= 3'd3)});
    @(negedge clk);
    md_start = 1'b0;
    lim = (op <= 3'd1) ? MC : (op <= 3'd3) ? DC : 0;
    cyc = 0;
    while (busy && cyc < 40) begin
      check_eq({tag, " hilo_hold"}, {hi, lo}, {m_hi, m_lo});
      check_eq({tag, " stall_busy"}, {63'd0, stall}, {63'd0, uses});
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, " busy_cycles"}, 64'(cyc), 64'(lim));
    check_eq({tag, " stall_done"}, {63'd0, stall}, 64'd0);
    e = exp_q.pop_front();
    check_eq({tag, " hilo"}, {hi, lo}, e);
    {m_hi, m_lo} = e;
    id_uses_md = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; md_start = 1'b0; md_op = 3'd0;
    rs_val = 32'd0; rt_val = 32'd0; id_uses_md = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_eq("reset_hilo", {hi, lo}, 64'd0);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);

    run_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "mult");
    check_eq("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu");
    check_eq("multu_const", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});
    run_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, "div_neg");
    check_eq("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, "divu_zero");
    check_eq("divu_zero_const", {hi, lo}, {32'h0000_0007, 32'hFFFF_FFFF});
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    check_eq("div_ovf_const", {hi, lo}, {32'h0000_0000, 32'h8000_0000});
    run_md(3'd2, 32'h0000_0064, 32'h0000_0000, 1'b0, "div_zero");
    run_md(3'd4, 32'h1234_5678, 32'h0, 1'b1, "mthi");
    check_eq("mthi_const", {32'd0, hi}, {32'd0, 32'h1234_5678});
    run_md(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, "mtlo");
    run_md(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b1, "op6");
    run_md(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0, "op7");

    for (int i = 0; i < 8; i++) begin
      logic [31:0] r_rt;
      r_rt = (i == 5) ? 32'd0 : $urandom;
      run_md(3'($urandom_range(0, 3)), $urandom, r_rt, 1'($urandom_range(0, 1)), "rand");
    end

    // Reset lands in the third busy cycle of a DIV; nothing may be committed afterwards.
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd2; rs_val = 32'd1000; rt_val = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_busy_pre", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (DC + 2) @(negedge clk);
    check_eq("rst_no_commit", {hi, lo}, 64'd0);
    check_eq("rst_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
